// File: rtl/cnn_layer_accel_pkg.sv
// Shared definitions for the CNN layer accelerator result path.
package cnn_layer_accel_pkg;

    localparam int C_RESULT_WIDTH = 16;
    localparam int C_OUT_WIDTH    = 128;
    localparam int C_LANES        = C_OUT_WIDTH / C_RESULT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } packer_state_t;

endpackage

// File: rtl/cnn_layer_accel_result_coord_cnt.sv
// Nested row/column/depth position counter, depth fastest, then column, then row.
module cnn_layer_accel_result_coord_cnt #(
    parameter int C_DIM_WIDTH = 10
) (
    input  logic                   clk_if,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   inc,
    input  logic [C_DIM_WIDTH-1:0] num_rows,
    input  logic [C_DIM_WIDTH-1:0] num_cols,
    input  logic [C_DIM_WIDTH-1:0] num_kernels,
    output logic [C_DIM_WIDTH-1:0] row,
    output logic [C_DIM_WIDTH-1:0] col,
    output logic [C_DIM_WIDTH-1:0] depth,
    output logic                   is_final
);

    logic [C_DIM_WIDTH-1:0] row_q, row_d;
    logic [C_DIM_WIDTH-1:0] col_q, col_d;
    logic [C_DIM_WIDTH-1:0] depth_q, depth_d;
    logic                   row_last, col_last, depth_last;

    // Next position: wrap each level at its configured extent and carry upward.
    always_comb begin
        row_last   = (row_q == num_rows - 1'b1);
        col_last   = (col_q == num_cols - 1'b1);
        depth_last = (depth_q == num_kernels - 1'b1);
        is_final   = row_last && col_last && depth_last;
        row_d      = row_q;
        col_d      = col_q;
        depth_d    = depth_q;
        if (clear) begin
            row_d   = '0;
            col_d   = '0;
            depth_d = '0;
        end else if (inc) begin
            if (depth_last) begin
                depth_d = '0;
                if (col_last) begin
                    col_d = '0;
                    row_d = row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                depth_d = depth_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            row_q   <= '0;
            col_q   <= '0;
            depth_q <= '0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            depth_q <= depth_d;
        end
    end

    assign row   = row_q;
    assign col   = col_q;
    assign depth = depth_q;

endmodule

// File: rtl/cnn_layer_accel_result_packer.sv
// Packs a job's 16-bit quad results eight per 128-bit writeback word, flushing
// a masked partial word at end of job and then pulsing job_done.
module cnn_layer_accel_result_packer #(
    parameter  int C_RESULT_WIDTH = 16,
    parameter  int C_OUT_WIDTH    = 128,
    parameter  int C_DIM_WIDTH    = 10,
    localparam int C_LANES        = C_OUT_WIDTH / C_RESULT_WIDTH
) (
    input  logic                      clk_if,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [C_DIM_WIDTH-1:0]    cfg_num_output_rows,
    input  logic [C_DIM_WIDTH-1:0]    cfg_num_output_cols,
    input  logic [C_DIM_WIDTH-1:0]    cfg_num_kernels,
    input  logic                      result_valid,
    output logic                      result_accept,
    input  logic [C_RESULT_WIDTH-1:0] result_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [C_OUT_WIDTH-1:0]    out_data,
    output logic [C_LANES-1:0]        out_keep,
    output logic                      out_last,
    output logic [C_DIM_WIDTH-1:0]    output_row,
    output logic [C_DIM_WIDTH-1:0]    output_col,
    output logic [C_DIM_WIDTH-1:0]    output_depth,
    output logic                      busy,
    output logic                      job_done
);

    import cnn_layer_accel_pkg::*;

    localparam int C_LANE_W = $clog2(C_LANES);

    packer_state_t                           state_q, state_d;
    logic [C_DIM_WIDTH-1:0]                  rows_q, rows_d, cols_q, cols_d, kern_q, kern_d;
    logic [C_LANE_W-1:0]                     lane_q, lane_d;
    logic [C_LANES-2:0][C_RESULT_WIDTH-1:0]  acc_q, acc_d;
    logic                                    out_valid_q, out_valid_d;
    logic [C_OUT_WIDTH-1:0]                  out_data_q, out_data_d;
    logic [C_LANES-1:0]                      out_keep_q, out_keep_d;
    logic                                    out_last_q, out_last_d;
    logic                                    cfg_fire, fire, drain, completing, is_final;
    logic                                    dim_zero;

    cnn_layer_accel_result_coord_cnt #(
        .C_DIM_WIDTH (C_DIM_WIDTH)
    ) u_coord_cnt (
        .clk_if      (clk_if),
        .rst         (rst),
        .clear       (cfg_fire),
        .inc         (fire),
        .num_rows    (rows_q),
        .num_cols    (cols_q),
        .num_kernels (kern_q),
        .row         (output_row),
        .col         (output_col),
        .depth       (output_depth),
        .is_final    (is_final)
    );

    // State register.
    always_ff @(posedge clk_if) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: an empty job skips straight to DONE; DRAIN waits for the last word to leave.
    always_comb begin
        dim_zero = (cfg_num_output_rows == '0) || (cfg_num_output_cols == '0) ||
                   (cfg_num_kernels == '0);
        state_d  = state_q;
        case (state_q)
            ST_IDLE:  if (cfg_valid) state_d = dim_zero ? ST_DONE : ST_RUN;
            ST_RUN:   if (fire && is_final) state_d = ST_DRAIN;
            ST_DRAIN: if (out_valid_q && out_ready) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and handshake qualifiers; a completing result waits only if the output register cannot free up.
    always_comb begin
        cfg_ready     = (state_q == ST_IDLE) && !rst;
        busy          = (state_q != ST_IDLE);
        job_done      = (state_q == ST_DONE);
        completing    = (lane_q == C_LANE_W'(C_LANES - 1)) || is_final;
        drain         = out_valid_q && out_ready;
        result_accept = (state_q == ST_RUN) && (!completing || !out_valid_q || out_ready);
        fire          = result_valid && result_accept;
        cfg_fire      = cfg_valid && cfg_ready;
    end

    // Packing datapath: accumulate lanes, then move accumulator plus completing result into the output register.
    always_comb begin
        rows_d      = rows_q;
        cols_d      = cols_q;
        kern_d      = kern_q;
        lane_d      = lane_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        if (cfg_fire) begin
            rows_d = cfg_num_output_rows;
            cols_d = cfg_num_output_cols;
            kern_d = cfg_num_kernels;
            lane_d = '0;
            acc_d  = '0;
        end
        if (drain) out_valid_d = 1'b0;
        if (fire) begin
            if (completing) begin
                out_valid_d = 1'b1;
                out_last_d  = is_final;
                out_data_d  = '0;
                for (int i = 0; i < C_LANES - 1; i++) begin
                    if (C_LANE_W'(i) < lane_q) out_data_d[i*C_RESULT_WIDTH +: C_RESULT_WIDTH] = acc_q[i];
                end
                out_data_d[int'(lane_q)*C_RESULT_WIDTH +: C_RESULT_WIDTH] = result_data;
                for (int i = 0; i < C_LANES; i++) begin
                    out_keep_d[i] = (C_LANE_W'(i) <= lane_q);
                end
                lane_d = '0;
                acc_d  = '0;
            end else begin
                acc_d[lane_q] = result_data;
                lane_d        = lane_q + 1'b1;
            end
        end
    end

    // Datapath registers; reset also discards any partial or pending word.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            rows_q      <= '0;
            cols_q      <= '0;
            kern_q      <= '0;
            lane_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            kern_q      <= kern_d;
            lane_q      <= lane_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Bench for the result packer: queue-based reference model checked every cycle,
// plus literal expectations for the directed jobs.
module tb_cnn_layer_accel_result_packer;

    logic         clk_if = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [9:0]   cfg_num_output_rows, cfg_num_output_cols, cfg_num_kernels;
    logic         result_valid;
    logic         result_accept;
    logic [15:0]  result_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [7:0]   out_keep;
    logic         out_last;
    logic [9:0]   output_row, output_col, output_depth;
    logic         busy;
    logic         job_done;

    always #5 clk_if = ~clk_if;

    cnn_layer_accel_result_packer dut (
        .clk_if              (clk_if),
        .rst                 (rst),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_num_output_rows (cfg_num_output_rows),
        .cfg_num_output_cols (cfg_num_output_cols),
        .cfg_num_kernels     (cfg_num_kernels),
        .result_valid        (result_valid),
        .result_accept       (result_accept),
        .result_data         (result_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_keep            (out_keep),
        .out_last            (out_last),
        .output_row          (output_row),
        .output_col          (output_col),
        .output_depth        (output_depth),
        .busy                (busy),
        .job_done            (job_done)
    );

    typedef struct {
        logic [127:0] data;
        logic [7:0]   keep;
        logic         last;
    } word_t;

    typedef struct {
        int r;
        int c;
        int d;
    } coord_t;

    int          errors = 0;
    int          checks = 0;
    word_t       exp_q[$];
    word_t       got_q[$];
    logic [15:0] cur[$];
    logic [15:0] vals[$];
    coord_t      coord_log[$];
    bit          m_act = 0;
    bit          done_exp = 0;
    int          m_r, m_c, m_k, total, n;
    int          rst_cycles = 0;
    int          cyc = 0;
    int          cfg_hs_cyc, last_hs_cyc, done_cyc;
    int          dut_done_cnt = 0;
    int          ready_mode = 0;
    bit          bp_armed = 0;
    int          bp_cnt = 0;

    task automatic check(input string nm, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // Reference model and per-cycle comparison, evaluated on the falling edge.
    always @(negedge clk_if) begin : cmp
        word_t w;
        bit    done_now, in_run, compl, exp_acc;
        cyc++;
        if (job_done) begin
            dut_done_cnt++;
            done_cyc = cyc;
        end
        if (rst) begin
            if (rst_cycles > 0) begin
                check("rst_cfg_ready", cfg_ready, 0);
                check("rst_busy", busy, 0);
                check("rst_job_done", job_done, 0);
                check("rst_out_valid", out_valid, 0);
                check("rst_accept", result_accept, 0);
                check("rst_out_data", out_data, 0);
                check("rst_out_keep", out_keep, 0);
                check("rst_out_last", out_last, 0);
                check("rst_coords", {output_row, output_col, output_depth}, 0);
            end
            rst_cycles++;
            m_act    = 0;
            done_exp = 0;
            n        = 0;
            exp_q.delete();
            cur.delete();
        end else begin
            rst_cycles = 0;
            done_now   = done_exp;
            done_exp   = 0;
            check("busy", busy, m_act);
            check("cfg_ready", cfg_ready, !m_act);
            check("job_done", job_done, done_now);
            check("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("out_data", out_data, exp_q[0].data);
                check("out_keep", out_keep, exp_q[0].keep);
                check("out_last", out_last, exp_q[0].last);
            end
            in_run  = m_act && (n < total);
            compl   = ((n % 8) == 7) || (n == total - 1);
            exp_acc = in_run && (!compl || exp_q.size() == 0 || out_ready);
            check("result_accept", result_accept, exp_acc);
            if (in_run) begin
                check("output_depth", output_depth, n % m_k);
                check("output_col", output_col, (n / m_k) % m_c);
                check("output_row", output_row, n / (m_k * m_c));
            end
            if (exp_q.size() != 0 && out_ready) begin
                w = exp_q.pop_front();
                got_q.push_back('{out_data, out_keep, out_last});
                if (w.last) begin
                    done_exp    = 1;
                    last_hs_cyc = cyc;
                end
            end
            if (exp_acc && result_valid) begin
                coord_log.push_back('{int'(output_row), int'(output_col), int'(output_depth)});
                cur.push_back(result_data);
                n++;
                if (cur.size() == 8 || n == total) begin
                    w.data = '0;
                    for (int i = 0; i < cur.size(); i++) w.data[i*16 +: 16] = cur[i];
                    w.keep = 8'((1 << cur.size()) - 1);
                    w.last = (n == total);
                    exp_q.push_back(w);
                    cur.delete();
                end
            end
            if (cfg_valid && !m_act) begin
                m_r        = int'(cfg_num_output_rows);
                m_c        = int'(cfg_num_output_cols);
                m_k        = int'(cfg_num_kernels);
                total      = m_r * m_c * m_k;
                n          = 0;
                m_act      = 1;
                cfg_hs_cyc = cyc;
                if (total == 0) done_exp = 1;
            end
            if (done_now) m_act = 0;
        end
    end

    // Downstream ready: always, random, or a 10-cycle stall once the first word appears.
    always begin
        @(posedge clk_if);
        #1;
        if (ready_mode == 2 && bp_armed && out_valid) begin
            bp_armed = 0;
            bp_cnt   = 10;
        end
        if (ready_mode == 1)      out_ready = 1'($urandom_range(0, 1));
        else if (bp_cnt > 0) begin
            out_ready = 1'b0;
            bp_cnt--;
        end else                  out_ready = 1'b1;
    end

    task automatic tick();
        @(posedge clk_if);
        #1;
    endtask

    task automatic run_job(input int r, input int c, input int k, input int nsend, input bit gaps);
        bit hs;
        bit ok;
        int t;
        cfg_valid           = 1'b1;
        cfg_num_output_rows = 10'(r);
        cfg_num_output_cols = 10'(c);
        cfg_num_kernels     = 10'(k);
        t = 0;
        do begin
            @(negedge clk_if);
            hs = cfg_ready;
            tick();
            t++;
        end while (!hs && t < 50);
        cfg_valid = 1'b0;
        if (!hs) check("cfg_handshake_timeout", 0, 1);
        for (int i = 0; i < nsend; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                result_valid = 1'b0;
                tick();
            end
            result_valid = 1'b1;
            result_data  = vals[i];
            t = 0;
            do begin
                @(negedge clk_if);
                ok = result_accept;
                tick();
                t++;
            end while (!ok && t < 100);
            if (!ok) check("result_accept_timeout", i, -1);
        end
        result_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int t = 0;
        while (dut_done_cnt == prev && t < 300) begin
            tick();
            t++;
        end
        check("job_done_seen", dut_done_cnt != prev, 1);
        tick();
    endtask

    task automatic chk_word(input string nm, input int idx, input logic [127:0] d,
                            input logic [7:0] k, input logic l);
        if (idx >= got_q.size()) check({nm, "_present"}, got_q.size(), idx + 1);
        else begin
            check({nm, "_data"}, got_q[idx].data, d);
            check({nm, "_keep"}, got_q[idx].keep, k);
            check({nm, "_last"}, got_q[idx].last, l);
        end
    endtask

    task automatic prep(input int cnt, input int base);
        vals.delete();
        for (int i = 0; i < cnt; i++) vals.push_back(16'(base + i));
        got_q.delete();
        coord_log.delete();
    endtask

    initial begin
        int prev;
        rst                 = 1'b1;
        cfg_valid           = 1'b0;
        cfg_num_output_rows = '0;
        cfg_num_output_cols = '0;
        cfg_num_kernels     = '0;
        result_valid        = 1'b0;
        result_data         = '0;
        out_ready           = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Full word: 2x2x2, results 1..8.
        prep(8, 1);
        prev = dut_done_cnt;
        run_job(2, 2, 2, 8, 0);
        wait_done(prev);
        check("full_word_count", got_q.size(), 1);
        chk_word("full_w0", 0, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 8'hFF, 1'b1);
        check("full_done_latency", done_cyc - last_hs_cyc, 1);

        // Partial final word: 3x3x1, results 0x10..0x18.
        prep(9, 16'h10);
        prev = dut_done_cnt;
        run_job(3, 3, 1, 9, 0);
        wait_done(prev);
        check("partial_word_count", got_q.size(), 2);
        chk_word("partial_w0", 0, 128'h0017_0016_0015_0014_0013_0012_0011_0010, 8'hFF, 1'b0);
        chk_word("partial_w1", 1, 128'h18, 8'h01, 1'b1);

        // Backpressure: 16 results, 10-cycle stall after word 1.
        prep(16, 1);
        ready_mode = 2;
        bp_armed   = 1;
        prev = dut_done_cnt;
        run_job(2, 2, 4, 16, 0);
        wait_done(prev);
        ready_mode = 0;
        check("bp_word_count", got_q.size(), 2);
        chk_word("bp_w0", 0, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 8'hFF, 1'b0);
        chk_word("bp_w1", 1, 128'h0010_000f_000e_000d_000c_000b_000a_0009, 8'hFF, 1'b1);

        // Zero dimension with result_valid held high throughout.
        prep(0, 0);
        result_valid = 1'b1;
        result_data  = 16'hdead;
        prev = dut_done_cnt;
        run_job(4, 4, 0, 0, 0);
        wait_done(prev);
        result_valid = 1'b0;
        check("zero_word_count", got_q.size(), 0);
        check("zero_done_latency", done_cyc - cfg_hs_cyc, 1);

        // Reset after 5 of 8 results, then a clean 8-result job.
        prep(8, 16'h40);
        run_job(2, 2, 2, 5, 0);
        prev = dut_done_cnt;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        check("reset_no_job_done", dut_done_cnt, prev);
        check("reset_no_word", got_q.size(), 0);
        prep(8, 16'h21);
        prev = dut_done_cnt;
        run_job(1, 2, 4, 8, 0);
        wait_done(prev);
        chk_word("post_reset_w0", 0, 128'h0028_0027_0026_0025_0024_0023_0022_0021, 8'hFF, 1'b1);

        // Coordinates: 2x3x4.
        prep(24, 16'h100);
        prev = dut_done_cnt;
        run_job(2, 3, 4, 24, 0);
        wait_done(prev);
        check("coord_count", coord_log.size(), 24);
        if (coord_log.size() == 24) begin
            check("coord_5", {coord_log[5].r[3:0], coord_log[5].c[3:0], coord_log[5].d[3:0]}, 12'h011);
            check("coord_last", {coord_log[23].r[3:0], coord_log[23].c[3:0], coord_log[23].d[3:0]}, 12'h123);
        end
        chk_word("coord_w2", 2, 128'h0117_0116_0115_0114_0113_0112_0111_0110, 8'hFF, 1'b1);

        // Randomized jobs with gaps and random downstream ready.
        ready_mode = 1;
        for (int j = 0; j < 8; j++) begin
            int r, c, k;
            r = $urandom_range(1, 3);
            c = $urandom_range(1, 3);
            k = $urandom_range(1, 4);
            prep(r * c * k, 0);
            for (int i = 0; i < r * c * k; i++) vals[i] = 16'($urandom);
            prev = dut_done_cnt;
            run_job(r, c, k, r * c * k, 1);
            wait_done(prev);
            check("rand_word_count", got_q.size(), (r * c * k + 7) / 8);
        end
        ready_mode = 0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
